// File: rtl/uc_recebe_dados.sv
// -----------------------------------------------------------------------------
// uc_recebe_dados
// Receive-side frame parser for the game-data link (counterpart of the send
// control unit). Consumes one byte per dado_valido strobe, locks onto the
// two-byte header, then demultiplexes the fixed-length frame:
//   CAB0, CAB1, pontuacao, opcode_nave, posicao_nave,
//   N_ASTE x {pos, opcode}, N_TIROS x {pos, opcode}, jogada_especial
// Scalars are staged during the frame and committed together in FIM, so the
// committed outputs never show a half-received frame.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   habilita            0 forces the parser back to ESPERA_CAB0
//   dado, dado_valido   received byte and its one-cycle strobe
//   pontuacao, opcode_nave, posicao_nave, jogada_especial
//                       committed scalars (change only in FIM)
//   we_aste, end_aste, pos_aste, opc_aste
//                       asteroid memory write port (1-cycle strobe)
//   we_tiro, end_tiro, pos_tiro, opc_tiro
//                       shot memory write port (1-cycle strobe)
//   quadro_pronto       high during FIM, same cycle the new scalars appear
//   erro_cabecalho      1-cycle pulse after a bad second header byte
//   erro_timeout        1-cycle pulse when an in-frame gap reaches TIMEOUT
//   db_estado           current state encoding
// -----------------------------------------------------------------------------
module uc_recebe_dados #(
    parameter int         N_ASTE  = 16,
    parameter int         N_TIROS = 16,
    parameter logic [7:0] CAB0    = 8'hA5,
    parameter logic [7:0] CAB1    = 8'h5A,
    parameter int         TIMEOUT = 50000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       habilita,
    input  logic [7:0]                 dado,
    input  logic                       dado_valido,
    output logic [7:0]                 pontuacao,
    output logic [7:0]                 opcode_nave,
    output logic [7:0]                 posicao_nave,
    output logic [7:0]                 jogada_especial,
    output logic                       we_aste,
    output logic [$clog2(N_ASTE)-1:0]  end_aste,
    output logic [7:0]                 pos_aste,
    output logic [7:0]                 opc_aste,
    output logic                       we_tiro,
    output logic [$clog2(N_TIROS)-1:0] end_tiro,
    output logic [7:0]                 pos_tiro,
    output logic [7:0]                 opc_tiro,
    output logic                       quadro_pronto,
    output logic                       erro_cabecalho,
    output logic                       erro_timeout,
    output logic [3:0]                 db_estado
);

    localparam int AW = $clog2(N_ASTE);
    localparam int TW = $clog2(N_TIROS);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        ESPERA_CAB0 = 4'd0,
        ESPERA_CAB1 = 4'd1,
        PONTUACAO   = 4'd2,
        OPCODE_NAVE = 4'd3,
        POS_NAVE    = 4'd4,
        POS_ASTE    = 4'd5,
        OPC_ASTE    = 4'd6,
        POS_TIRO    = 4'd7,
        OPC_TIRO    = 4'd8,
        ESPECIAL    = 4'd9,
        FIM         = 4'd10
    } estado_t;

    estado_t        estado, estado_next;
    logic [AW-1:0]  idx_aste;
    logic [TW-1:0]  idx_tiro;
    logic [CW-1:0]  timer;
    logic [7:0]     stg_pontuacao, stg_opcode_nave, stg_posicao_nave;
    logic [7:0]     pos_lat;
    logic           conta, timeout_hit;
    logic           ultimo_aste, ultimo_tiro;

    // The idle timer only runs while a frame is in progress.
    assign conta       = habilita && (estado != ESPERA_CAB0) && (estado != FIM);
    assign timeout_hit = conta && !dado_valido && (timer == CW'(TIMEOUT - 1));
    assign ultimo_aste = (idx_aste == AW'(N_ASTE - 1));
    assign ultimo_tiro = (idx_tiro == TW'(N_TIROS - 1));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= ESPERA_CAB0;
        else       estado <= estado_next;
    end

    // Next-state logic
    always_comb begin
        estado_next = estado;
        if (!habilita || timeout_hit) begin
            estado_next = ESPERA_CAB0;
        end else begin
            case (estado)
                ESPERA_CAB0: if (dado_valido && dado == CAB0) estado_next = ESPERA_CAB1;
                ESPERA_CAB1: if (dado_valido) begin
                    if (dado == CAB1)      estado_next = PONTUACAO;
                    else if (dado == CAB0) estado_next = ESPERA_CAB1;
                    else                   estado_next = ESPERA_CAB0;
                end
                PONTUACAO:   if (dado_valido) estado_next = OPCODE_NAVE;
                OPCODE_NAVE: if (dado_valido) estado_next = POS_NAVE;
                POS_NAVE:    if (dado_valido) estado_next = POS_ASTE;
                POS_ASTE:    if (dado_valido) estado_next = OPC_ASTE;
                OPC_ASTE:    if (dado_valido) estado_next = ultimo_aste ? POS_TIRO : POS_ASTE;
                POS_TIRO:    if (dado_valido) estado_next = OPC_TIRO;
                OPC_TIRO:    if (dado_valido) estado_next = ultimo_tiro ? ESPECIAL : POS_TIRO;
                ESPECIAL:    if (dado_valido) estado_next = FIM;
                FIM:         estado_next = ESPERA_CAB0;
                default:     estado_next = ESPERA_CAB0;
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        db_estado     = estado;
        quadro_pronto = (estado == FIM);
    end

    // Datapath: staging, write ports, indices, timer and error pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pontuacao        <= '0;
            opcode_nave      <= '0;
            posicao_nave     <= '0;
            jogada_especial  <= '0;
            we_aste          <= 1'b0;
            end_aste         <= '0;
            pos_aste         <= '0;
            opc_aste         <= '0;
            we_tiro          <= 1'b0;
            end_tiro         <= '0;
            pos_tiro         <= '0;
            opc_tiro         <= '0;
            erro_cabecalho   <= 1'b0;
            erro_timeout     <= 1'b0;
            idx_aste         <= '0;
            idx_tiro         <= '0;
            timer            <= '0;
            stg_pontuacao    <= '0;
            stg_opcode_nave  <= '0;
            stg_posicao_nave <= '0;
            pos_lat          <= '0;
        end else begin
            we_aste        <= 1'b0;
            we_tiro        <= 1'b0;
            erro_cabecalho <= 1'b0;
            erro_timeout   <= 1'b0;

            if (!conta || dado_valido || timeout_hit) timer <= '0;
            else                                      timer <= timer + CW'(1);

            if (!habilita) begin
                idx_aste <= '0;
                idx_tiro <= '0;
            end else if (timeout_hit) begin
                // Abort: discard staged scalars; written entries stay as they are.
                erro_timeout     <= 1'b1;
                idx_aste         <= '0;
                idx_tiro         <= '0;
                stg_pontuacao    <= '0;
                stg_opcode_nave  <= '0;
                stg_posicao_nave <= '0;
            end else if (dado_valido) begin
                case (estado)
                    ESPERA_CAB1: if (dado != CAB1) erro_cabecalho <= 1'b1;
                    PONTUACAO:   stg_pontuacao    <= dado;
                    OPCODE_NAVE: stg_opcode_nave  <= dado;
                    POS_NAVE:    stg_posicao_nave <= dado;
                    POS_ASTE:    pos_lat <= dado;
                    OPC_ASTE: begin
                        we_aste  <= 1'b1;
                        end_aste <= idx_aste;
                        pos_aste <= pos_lat;
                        opc_aste <= dado;
                        idx_aste <= ultimo_aste ? '0 : idx_aste + AW'(1);
                    end
                    POS_TIRO:    pos_lat <= dado;
                    OPC_TIRO: begin
                        we_tiro  <= 1'b1;
                        end_tiro <= idx_tiro;
                        pos_tiro <= pos_lat;
                        opc_tiro <= dado;
                        idx_tiro <= ultimo_tiro ? '0 : idx_tiro + TW'(1);
                    end
                    // Commit on the edge into FIM so the new scalars are
                    // visible in the same cycle as quadro_pronto.
                    ESPECIAL: begin
                        pontuacao       <= stg_pontuacao;
                        opcode_nave     <= stg_opcode_nave;
                        posicao_nave    <= stg_posicao_nave;
                        jogada_especial <= dado;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
